// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  // Transaction sequencing: accept, drive the memory request, await the response, return it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RET   = 2'd3
  } state_t;

  // Requester identity, used for both the current owner and the last winner.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. Purely combinational; the caller owns the
// last-winner register and decides when it advances.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last,
  output logic grant_valid,
  output logic grant
);

  // A lone requester wins; on a tie the one that did not win last time wins.
  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    if (lsu_valid && (!ifu_valid || (last == OWN_IFU))) begin
      grant = OWN_LSU;
    end else begin
      grant = OWN_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Non-pipelined arbiter sharing one memory port between the IFU and the LSU.
// Exactly one transaction is in flight; request fields and the response data
// are held in registers so the memory and requester sides see stable values.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ifu_req_valid,
  output logic                  o_ifu_req_ready,
  input  logic [ADDR_W-1:0]     i_ifu_addr,
  output logic                  o_ifu_resp_valid,
  input  logic                  i_ifu_resp_ready,
  output logic [DATA_W-1:0]     o_ifu_rdata,
  input  logic                  i_lsu_req_valid,
  output logic                  o_lsu_req_ready,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wmask,
  output logic                  o_lsu_resp_valid,
  input  logic                  i_lsu_resp_ready,
  output logic [DATA_W-1:0]     o_lsu_rdata,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_wen,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wmask,
  input  logic                  i_mem_resp_valid,
  output logic                  o_mem_resp_ready,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_owner
);

  localparam int MASK_W = DATA_W / 8;

  state_t              state_reg, state_next;
  logic                last_reg;
  logic                owner_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic grant_valid;
  logic grant;
  logic resp_fire;

  rr_arb2 u_rr_arb2 (
    .ifu_valid   (i_ifu_req_valid),
    .lsu_valid   (i_lsu_req_valid),
    .last        (last_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // The owning requester's response ready completes the return phase.
  assign resp_fire = (owner_reg == OWN_LSU) ? i_lsu_resp_ready : i_ifu_resp_ready;

  // Next state and handshake outputs; request readies depend only on state and requester valids.
  always_comb begin
    state_next       = state_reg;
    o_ifu_req_ready  = 1'b0;
    o_lsu_req_ready  = 1'b0;
    o_mem_req_valid  = 1'b0;
    o_mem_resp_ready = 1'b0;
    o_ifu_resp_valid = 1'b0;
    o_lsu_resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ifu_req_ready = grant_valid && (grant == OWN_IFU);
        o_lsu_req_ready = grant_valid && (grant == OWN_LSU);
        if (grant_valid) state_next = ISSUE;
      end
      ISSUE: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        o_mem_resp_ready = 1'b1;
        if (i_mem_resp_valid) state_next = RET;
      end
      RET: begin
        o_ifu_resp_valid = (owner_reg == OWN_IFU);
        o_lsu_resp_valid = (owner_reg == OWN_LSU);
        if (resp_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; the round-robin pointer only advances once a response is delivered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      last_reg  <= OWN_IFU;
    end else begin
      state_reg <= state_next;
      if ((state_reg == RET) && resp_fire) last_reg <= owner_reg;
    end
  end

  // Latch the winning request at acceptance and the memory data when it returns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_reg <= OWN_IFU;
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && grant_valid) begin
        owner_reg <= grant;
        if (grant == OWN_LSU) begin
          addr_reg  <= i_lsu_addr;
          wen_reg   <= i_lsu_wen;
          wdata_reg <= i_lsu_wdata;
          wmask_reg <= i_lsu_wmask;
        end else begin
          // Instruction fetches are always reads with no store payload.
          addr_reg  <= i_ifu_addr;
          wen_reg   <= 1'b0;
          wdata_reg <= '0;
          wmask_reg <= '0;
        end
      end
      if ((state_reg == WAIT) && i_mem_resp_valid) rdata_reg <= i_mem_rdata;
    end
  end

  assign o_mem_addr  = addr_reg;
  assign o_mem_wen   = wen_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_mem_wmask = wmask_reg;
  assign o_ifu_rdata = rdata_reg;
  assign o_lsu_rdata = rdata_reg;
  assign o_owner     = owner_reg;

endmodule
